// File: rtl/iir_pkg.sv
// Shared constants and sample types for the IIR output formatting path.
//   IIR_W / OUT_W        : raw IIR sample width and formatted sample width
//   SAT_CNT_W            : width of the optional saturation event counter
//   DROP_CNT_W           : width of the dropped-sample counter
package iir_pkg;

  localparam int unsigned IIR_W      = 20;
  localparam int unsigned OUT_W      = 8;
  localparam int unsigned SAT_CNT_W  = 16;
  localparam int unsigned DROP_CNT_W = 8;

  typedef logic [IIR_W-1:0] iir_sample_t;
  typedef logic [OUT_W-1:0] fmt_sample_t;

  // Result of scaling one IIR sample: clamped data plus the saturation flag.
  typedef struct packed {
    logic        sat;
    fmt_sample_t data;
  } fmt_result_t;

endpackage

// File: rtl/iir_fmt_fifo.sv
// DEPTH x 8 synchronous FIFO with a registered head.
// A push on a full FIFO is still accepted when a pop happens in the same cycle.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push, wdata   : write request and formatted sample
//   ready         : consumer accept; pop = dout_valid & ready
//   dout          : registered head entry
//   dout_valid    : registered non-empty flag
//   drop_c        : combinational, high when a push is rejected (full, no pop)
module iir_fmt_fifo
  import iir_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [OUT_W-1:0] wdata,
  input  logic             ready,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  output logic             drop_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fmt_sample_t      mem [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W-1:0] rptr_inc;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_n;
  logic             full;
  logic             empty;
  logic             pop;
  logic             wr_en;
  fmt_sample_t      head_n;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = dout_valid & ready;
  assign wr_en    = push & (~full | pop);
  assign drop_c   = push & full & ~pop;
  assign rptr_inc = rptr_q + PTR_W'(1);

  // Next occupancy and next head value after this cycle's push/pop.
  always_comb begin
    count_n = count_q;
    head_n  = dout;
    case ({wr_en, pop})
      2'b10:   count_n = count_q + CNT_W'(1);
      2'b01:   count_n = count_q - CNT_W'(1);
      default: count_n = count_q;
    endcase
    if (pop) begin
      // The entry behind the popped one is already stored when count > 1;
      // otherwise the only candidate for the new head is this cycle's write.
      if (count_q > CNT_W'(1)) begin
        head_n = mem[rptr_inc];
      end else if (wr_en) begin
        head_n = wdata;
      end
    end else if (empty && wr_en) begin
      head_n = wdata;
    end
  end

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_q] <= wdata;
    end
  end

  // Pointers, count and registered head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_q <= rptr_inc;
      end
      count_q    <= count_n;
      dout       <= head_n;
      dout_valid <= (count_n != '0);
    end
  end

endmodule

// File: rtl/iir_out_formatter.sv
// Formats the 20-bit IIR core output to 8 bits (round-half-up, unsigned
// saturation), aligns it with a delayed copy of the core's valid, and buffers
// results in a FIFO behind a valid/ready interface.
// Optional build macro IIR_SAT_CNT_EN adds the sat_cnt_21 saturation counter.
// Ports:
//   clk_21, rst_21      : clock, asynchronous active-high reset
//   iir_dv_21           : IIR core data_valid, delayed VLD_DLY cycles
//   iir_dout_21         : IIR core output sample (unsigned)
//   dout_21             : formatted sample at FIFO head (registered)
//   dout_valid_21       : FIFO non-empty (registered)
//   dout_ready_21       : consumer accept
//   ovf_21              : sticky overflow, a sample was dropped
//   drop_cnt_21         : dropped-sample count, saturating at 255
//   sat_cnt_21          : (IIR_SAT_CNT_EN) accepted saturated samples, saturating
module iir_out_formatter
  import iir_pkg::*;
#(
  parameter int unsigned SHIFT   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned VLD_DLY = 1
) (
  input  logic                  clk_21,
  input  logic                  rst_21,
  input  logic                  iir_dv_21,
  input  logic [IIR_W-1:0]      iir_dout_21,
  output logic [OUT_W-1:0]      dout_21,
  output logic                  dout_valid_21,
  input  logic                  dout_ready_21,
  output logic                  ovf_21,
  output logic [DROP_CNT_W-1:0] drop_cnt_21
`ifdef IIR_SAT_CNT_EN
  ,
  output logic [SAT_CNT_W-1:0]  sat_cnt_21
`endif
);

  // One extra bit so the rounding add cannot wrap.
  localparam int unsigned       CALC_W = IIR_W + 1;
  localparam logic [CALC_W-1:0] HALF   = CALC_W'(1) << (SHIFT - 1);
  localparam logic [CALC_W-1:0] OUT_MAX = CALC_W'((2 ** OUT_W) - 1);

  logic              vld_a;
  logic [CALC_W-1:0] rounded;
  fmt_result_t       fmt_res;
  logic              drop_c;

  // Valid delay line aligning the core's valid with its output data.
  generate
    if (VLD_DLY == 0) begin : g_no_dly
      assign vld_a = iir_dv_21;
    end else begin : g_dly
      logic [VLD_DLY-1:0] dly_q;
      always_ff @(posedge clk_21 or posedge rst_21) begin
        if (rst_21) begin
          dly_q <= '0;
        end else begin
          dly_q <= VLD_DLY'({dly_q, iir_dv_21});
        end
      end
      assign vld_a = dly_q[VLD_DLY-1];
    end
  endgenerate

  // Round-half-up scaling with unsigned clamp to the output width.
  always_comb begin
    rounded      = (CALC_W'(iir_dout_21) + HALF) >> SHIFT;
    fmt_res.sat  = (rounded > OUT_MAX);
    fmt_res.data = fmt_res.sat ? '1 : rounded[OUT_W-1:0];
  end

  iir_fmt_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk_21),
    .rst        (rst_21),
    .push       (vld_a),
    .wdata      (fmt_res.data),
    .ready      (dout_ready_21),
    .dout       (dout_21),
    .dout_valid (dout_valid_21),
    .drop_c     (drop_c)
  );

  // Overflow flag and saturating drop counter.
  always_ff @(posedge clk_21 or posedge rst_21) begin
    if (rst_21) begin
      ovf_21      <= 1'b0;
      drop_cnt_21 <= '0;
    end else if (drop_c) begin
      ovf_21 <= 1'b1;
      if (drop_cnt_21 != '1) begin
        drop_cnt_21 <= drop_cnt_21 + DROP_CNT_W'(1);
      end
    end
  end

`ifdef IIR_SAT_CNT_EN
  // Counts only saturated samples that actually entered the FIFO.
  always_ff @(posedge clk_21 or posedge rst_21) begin
    if (rst_21) begin
      sat_cnt_21 <= '0;
    end else if (vld_a && !drop_c && fmt_res.sat && (sat_cnt_21 != '1)) begin
      sat_cnt_21 <= sat_cnt_21 + SAT_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_iir_out_formatter.sv
// Self-checking bench for iir_out_formatter (SHIFT=8, DEPTH=4, VLD_DLY=1).
module tb_iir_out_formatter;

  localparam int unsigned SHIFT   = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned VLD_DLY = 1;

  logic        clk_21;
  logic        rst_21;
  logic        iir_dv_21;
  logic [19:0] iir_dout_21;
  logic [7:0]  dout_21;
  logic        dout_valid_21;
  logic        dout_ready_21;
  logic        ovf_21;
  logic [7:0]  drop_cnt_21;
`ifdef IIR_SAT_CNT_EN
  logic [15:0] sat_cnt_21;
`endif

  iir_out_formatter #(
    .SHIFT   (SHIFT),
    .DEPTH   (DEPTH),
    .VLD_DLY (VLD_DLY)
  ) dut (
    .clk_21        (clk_21),
    .rst_21        (rst_21),
    .iir_dv_21     (iir_dv_21),
    .iir_dout_21   (iir_dout_21),
    .dout_21       (dout_21),
    .dout_valid_21 (dout_valid_21),
    .dout_ready_21 (dout_ready_21),
    .ovf_21        (ovf_21),
    .drop_cnt_21   (drop_cnt_21)
`ifdef IIR_SAT_CNT_EN
    ,
    .sat_cnt_21    (sat_cnt_21)
`endif
  );

  initial clk_21 = 1'b0;
  always #5 clk_21 = ~clk_21;

  int total = 0;
  int bad   = 0;

  // Reference model state: buffered samples, drop statistics, valid history.
  logic [7:0] q[$];
  logic       m_ovf;
  int         m_drop;
  int         m_sat;
  logic       dv_hist;

  function automatic int unsigned rounded(input logic [19:0] x);
    return (int'(x) + (2 ** (SHIFT - 1))) / (2 ** SHIFT);
  endfunction

  function automatic logic [7:0] fmt(input logic [19:0] x);
    int unsigned r;
    r = rounded(x);
    return (r > 255) ? 8'hFF : 8'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_drop  = 0;
    m_sat   = 0;
    dv_hist = 1'b0;
  endtask

  // One clock edge of the model: pop before push, so a full FIFO with a pop
  // still accepts the incoming sample.
  task automatic model_edge(input logic dv, input logic [19:0] d, input logic rdy);
    if (rdy && q.size() != 0) void'(q.pop_front());
    if (dv_hist) begin
      if (q.size() < int'(DEPTH)) begin
        q.push_back(fmt(d));
        if (rounded(d) > 255 && m_sat < 65535) m_sat++;
      end else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    dv_hist = dv;
  endtask

  task automatic check_all();
    chk("valid", 32'(dout_valid_21), 32'(q.size() != 0));
    if (q.size() != 0) chk("head", 32'(dout_21), 32'(q[0]));
    chk("ovf", 32'(ovf_21), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt_21), 32'(m_drop));
`ifdef IIR_SAT_CNT_EN
    chk("sat_cnt", 32'(sat_cnt_21), 32'(m_sat));
`endif
  endtask

  // Drive inputs, advance one clock, update the model, check on the falling edge.
  task automatic cycle(input logic dv, input logic [19:0] d, input logic rdy);
    iir_dv_21     = dv;
    iir_dout_21   = d;
    dout_ready_21 = rdy;
    @(posedge clk_21);
    model_edge(dv, d, rdy);
    @(negedge clk_21);
    check_all();
  endtask

  initial begin
    rst_21        = 1'b1;
    iir_dv_21     = 1'b0;
    iir_dout_21   = '0;
    dout_ready_21 = 1'b0;
    model_reset();

    // Reset state.
    #1;
    chk("rst_dout", 32'(dout_21), 32'h0);
    chk("rst_valid", 32'(dout_valid_21), 32'h0);
    chk("rst_ovf", 32'(ovf_21), 32'h0);
    chk("rst_drop", 32'(drop_cnt_21), 32'h0);
    @(negedge clk_21);
    @(negedge clk_21);
    rst_21 = 1'b0;
    cycle(1'b0, 20'h0, 1'b1);

    // Rounding and saturation with ready held high.
    cycle(1'b1, 20'h12345, 1'b1);
    cycle(1'b1, 20'h00180, 1'b1);
    chk("round_180", 32'(dout_21), 32'h02);
    cycle(1'b1, 20'h0017F, 1'b1);
    chk("round_17f", 32'(dout_21), 32'h01);
    cycle(1'b1, 20'h00000, 1'b1);
    chk("round_0", 32'(dout_21), 32'h00);
    cycle(1'b0, 20'd355725, 1'b1);
    chk("sat_max", 32'(dout_21), 32'hFF);
`ifdef IIR_SAT_CNT_EN
    chk("sat_cnt_one", 32'(sat_cnt_21), 32'd1);
`endif
    cycle(1'b0, 20'h0, 1'b1);
    chk("drained", 32'(dout_valid_21), 32'h0);

    // Alignment: valid pulse one cycle ahead of its data.
    cycle(1'b1, 20'hABCDE, 1'b1);
    chk("align_early", 32'(dout_valid_21), 32'h0);
    cycle(1'b0, 20'h00500, 1'b1);
    chk("align_valid", 32'(dout_valid_21), 32'h1);
    chk("align_data", 32'(dout_21), 32'h05);
    cycle(1'b0, 20'h0, 1'b1);

    // Backpressure: six pushes into four entries.
    cycle(1'b1, 20'h0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(i < 5, 20'(32'h100 * (i + 1)), 1'b0);
    chk("ovf_set", 32'(ovf_21), 32'h1);
    chk("ovf_drops", 32'(drop_cnt_21), 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 32'(dout_21), 32'(i + 1));
      cycle(1'b0, 20'h0, 1'b1);
    end
    chk("drain_empty", 32'(dout_valid_21), 32'h0);

    // Full FIFO with simultaneous push and pop: nothing dropped.
    cycle(1'b1, 20'h0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 20'(32'h100 * (i + 7)), 1'b0);
    cycle(1'b0, 20'h00B00, 1'b1);
    chk("full_pp_drop", 32'(drop_cnt_21), 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("full_pp_order", 32'(dout_21), 32'(i + 8));
      cycle(1'b0, 20'h0, 1'b1);
    end
    chk("full_pp_empty", 32'(dout_valid_21), 32'h0);

    // Randomized traffic, including near-boundary sample values.
    for (int i = 0; i < 400; i++) begin
      logic [19:0] d;
      case ($urandom_range(0, 3))
        0:       d = 20'($urandom_range(65280, 65535));
        1:       d = 20'($urandom_range(0, 1023));
        default: d = 20'($urandom_range(0, 20'hFFFFF));
      endcase
      cycle($urandom_range(0, 3) != 0, d, (i % 100 < 60) ? ($urandom_range(0, 3) != 0)
                                                         : ($urandom_range(0, 4) == 0));
    end

    // Long stall drives the drop counter into saturation.
    for (int i = 0; i < 300; i++) cycle(1'b1, 20'(i * 37), 1'b0);
    chk("drop_sat", 32'(drop_cnt_21), 32'd255);

    // Leave three entries buffered plus a valid in flight, then reset between edges.
    cycle(1'b0, 20'h00300, 1'b0);
    cycle(1'b0, 20'h0, 1'b1);
    cycle(1'b1, 20'h0, 1'b0);
    #2;
    rst_21 = 1'b1;
    #1;
    chk("arst_valid", 32'(dout_valid_21), 32'h0);
    chk("arst_ovf", 32'(ovf_21), 32'h0);
    chk("arst_drop", 32'(drop_cnt_21), 32'h0);
    chk("arst_dout", 32'(dout_21), 32'h0);
    model_reset();
    iir_dv_21     = 1'b0;
    dout_ready_21 = 1'b1;
    @(negedge clk_21);
    rst_21 = 1'b0;
    cycle(1'b0, 20'hFFFFF, 1'b1);
    cycle(1'b0, 20'hFFFFF, 1'b1);
    chk("post_rst_idle", 32'(dout_valid_21), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
